rpn_calc: RTL and testbench
===========================

RPN_CALC -- requirements
Module: rpn_calc

Interface
REQ-001 Parameter B, default 8, data width; SHALL match the attached stack's data width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 tok_valid  in  1  token present on tok_is_op/tok_data.
REQ-005 tok_ready  out  1  block accepts a token this cycle; accept = tok_valid & tok_ready.
REQ-006 tok_is_op  in  1  1 = operator token, 0 = operand token.
REQ-007 tok_data  in  B  operand value, or opcode in bits [1:0] when tok_is_op=1.
REQ-008 clr  in  1  clear error and drain stack.
REQ-009 stk_push  out  1  push strobe to stack.
REQ-010 stk_pop  out  1  pop strobe to stack.
REQ-011 stk_wdata  out  B  data to push.
REQ-012 stk_rdata  in  B  stack top; valid combinationally in the same cycle stk_pop=1.
REQ-013 stk_full, stk_empty  in  1 each  stack status flags.
REQ-014 result  out  B  last computed value, registered.
REQ-015 result_valid  out  1  one-cycle pulse when result updates.
REQ-016 err  out  1  sticky error flag.
REQ-017 err_code  out  2  01 underflow, 10 overflow, 00 none.

Function
REQ-018 States SHALL be IDLE, POP_B, POP_A, PUSH_R, ERR, DRAIN.
REQ-019 tok_ready SHALL be 1 only in IDLE with clr=0.
REQ-020 IDLE, operand accepted, stk_full=0: stk_push=1 and stk_wdata=tok_data in the same cycle; remain in IDLE.
REQ-021 IDLE, operand accepted, stk_full=1: no push; next state ERR, err_code=10.
REQ-022 IDLE, operator accepted: latch tok_data[1:0] as the opcode; next state POP_B.
REQ-023 POP_B: if stk_empty=1, go to ERR with err_code=01; else stk_pop=1, b_reg<=stk_rdata, go to POP_A.
REQ-024 POP_A: same rule as POP_B, capturing into a_reg instead; on success go to PUSH_R.
REQ-025 PUSH_R: stk_push=1, stk_wdata=a_reg OP b_reg; result<=the same value; result_valid=1 on the next cycle; next state IDLE.
REQ-026 Opcodes: 00 a+b, 01 a-b, 10 a&b, 11 a^b; all results modulo 2^B, carry/borrow discarded.
REQ-027 Operator latency: accept in cycle N; pops in N+1 and N+2; push in N+3; result_valid in N+4; next token acceptable in N+4.
REQ-028 Underflow in POP_A SHALL leave the already-popped b value discarded; it is not restored.
REQ-029 stk_push and stk_pop SHALL never be asserted in the same cycle.
REQ-030 ERR: err=1, tok_ready=0, no stack strobes; held until clr or reset.
REQ-031 clr=1 in IDLE or ERR: go to DRAIN.
REQ-032 clr in POP_B, POP_A or PUSH_R SHALL be ignored.
REQ-033 DRAIN: stk_pop=1 each cycle while stk_empty=0; when stk_empty=1, clear err and err_code and go to IDLE.
REQ-034 result SHALL hold its value across errors and drains.

Reset
REQ-035 reset=1 at any clock edge: state=IDLE; result, a_reg, b_reg=0; result_valid=0; err=0; err_code=00.
REQ-036 During reset, stk_push=0 and stk_pop=0.
REQ-037 A reset in mid-operation SHALL abandon the operation with no further strobes.
REQ-038 The stack SHALL be reset by the same reset net.

Structure
REQ-039 Package rpn_pkg SHALL hold the opcode constants, state encoding and err_code constants.
REQ-040 Sub-module rpn_alu (combinational: a, b, op -> y) SHALL implement REQ-026.
REQ-041 All outputs except tok_ready, stk_push, stk_pop and stk_wdata SHALL be registered.

Verification
REQ-042 Push 3, push 4, op 00 -> stk_push with 7 at N+3; result=7 with result_valid at N+4; stack holds one entry.
REQ-043 Push 5, push 7, op 01 -> result=0xFE (B=8); op 00 on 0xFF and 0x02 -> 0x01.
REQ-044 Push 9, op 00 -> one pop, then err=1, err_code=01, tok_ready=0; stk_empty=1.
REQ-045 With stk_full=1, push 1 -> no stk_push; err_code=10; clr -> pops until empty, then err=0 and tok_ready=1.
REQ-046 reset asserted in POP_A -> next cycle state IDLE, all outputs at reset values, no strobes.
REQ-047 tok_valid held high with mixed tokens -> tok_ready low in POP_B, POP_A and PUSH_R; no token lost or duplicated.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared constants for the RPN calculator: opcodes, FSM state encoding and
// error codes.
package rpn_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP_B  = 3'd1,
        ST_POP_A  = 3'd2,
        ST_PUSH_R = 3'd3,
        ST_ERR    = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic unit: y = a OP b, wrapping modulo 2^B.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int B = 8
) (
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    input  logic [1:0]   op,
    output logic [B-1:0] y
);

    // Opcode decode; carry and borrow fall off the top bit.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_calc.sv
// RPN calculator sequencer: pushes operands, pops two values per operator,
// pushes the result back, and flags stack underflow/overflow.
module rpn_calc
    import rpn_pkg::*;
#(
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic [B-1:0] tok_data,
    input  logic         clr,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [B-1:0] stk_wdata,
    input  logic [B-1:0] stk_rdata,
    input  logic         stk_full,
    input  logic         stk_empty,
    output logic [B-1:0] result,
    output logic         result_valid,
    output logic         err,
    output logic [1:0]   err_code
);

    state_t       state_r;
    logic [1:0]   op_r;
    logic [B-1:0] a_r;
    logic [B-1:0] b_r;
    logic [B-1:0] result_r;
    logic         result_valid_r;
    logic         err_r;
    logic [1:0]   err_code_r;
    logic [B-1:0] alu_y_s;
    logic         accept_s;

    rpn_alu #(.B(B)) u_alu (
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .y  (alu_y_s)
    );

    // Gating with reset keeps every strobe quiet while reset is held.
    assign tok_ready = (state_r == ST_IDLE) && !clr && !reset;
    assign accept_s  = tok_valid && tok_ready;

    // Stack strobe generation; push and pop are mutually exclusive per state.
    always_comb begin
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        if (reset) begin
            stk_push = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !tok_is_op && !stk_full) begin
                        stk_push  = 1'b1;
                        stk_wdata = tok_data;
                    end else begin
                        stk_push = 1'b0;
                    end
                end
                ST_POP_B, ST_POP_A, ST_DRAIN: begin
                    stk_pop = !stk_empty;
                end
                ST_PUSH_R: begin
                    stk_push  = 1'b1;
                    stk_wdata = alu_y_s;
                end
                default: begin
                    stk_push = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, operand capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            op_r           <= 2'b00;
            a_r            <= '0;
            b_r            <= '0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
            err_code_r     <= ERR_NONE;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clr) begin
                        state_r <= ST_DRAIN;
                    end else if (accept_s && tok_is_op) begin
                        op_r    <= tok_data[1:0];
                        state_r <= ST_POP_B;
                    end else if (accept_s && stk_full) begin
                        err_r      <= 1'b1;
                        err_code_r <= ERR_OVER;
                        state_r    <= ST_ERR;
                    end
                end
                ST_POP_B: begin
                    if (stk_empty) begin
                        err_r      <= 1'b1;
                        err_code_r <= ERR_UNDER;
                        state_r    <= ST_ERR;
                    end else begin
                        b_r     <= stk_rdata;
                        state_r <= ST_POP_A;
                    end
                end
                ST_POP_A: begin
                    if (stk_empty) begin
                        err_r      <= 1'b1;
                        err_code_r <= ERR_UNDER;
                        state_r    <= ST_ERR;
                    end else begin
                        a_r     <= stk_rdata;
                        state_r <= ST_PUSH_R;
                    end
                end
                ST_PUSH_R: begin
                    result_r       <= alu_y_s;
                    result_valid_r <= 1'b1;
                    state_r        <= ST_IDLE;
                end
                ST_ERR: begin
                    if (clr) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (stk_empty) begin
                        err_r      <= 1'b0;
                        err_code_r <= ERR_NONE;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign err          = err_r;
    assign err_code     = err_code_r;

endmodule

// File: tb/tb_rpn_calc.sv
// Directed bench for rpn_calc with a 4-deep behavioural stack attached.
module tb_rpn_calc;

    logic       clk;
    logic       reset;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_is_op;
    logic [7:0] tok_data;
    logic       clr;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_wdata;
    logic [7:0] stk_rdata;
    logic       stk_full;
    logic       stk_empty;
    logic [7:0] result;
    logic       result_valid;
    logic       err;
    logic [1:0] err_code;

    int compared   = 0;
    int mismatched = 0;

    rpn_calc #(.B(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .clr          (clr),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_wdata    (stk_wdata),
        .stk_rdata    (stk_rdata),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model, reset by the same reset net as the calculator.
    logic [7:0] mem [0:3];
    logic [2:0] cnt;
    logic [1:0] top_idx;
    assign top_idx   = cnt[1:0] - 2'd1;
    assign stk_full  = (cnt == 3'd4);
    assign stk_empty = (cnt == 3'd0);
    assign stk_rdata = stk_empty ? 8'h00 : mem[top_idx];

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (stk_push && !stk_full) begin
            mem[cnt[1:0]] <= stk_wdata;
            cnt           <= cnt + 3'd1;
        end else if (stk_pop && !stk_empty) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Strobe and result-pulse counters.
    int push_cnt = 0;
    int pop_cnt  = 0;
    int both_cnt = 0;
    int rv_cnt   = 0;
    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
        if (result_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_operand(input logic [7:0] v);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = v;
        #1;
        check("push_strobe", {31'd0, stk_push}, 32'd1);
        check("push_wdata", {24'd0, stk_wdata}, {24'd0, v});
        @(negedge clk);
        tok_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] opc, input logic [7:0] exp);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = {6'd0, opc};
        #1;
        check("op_accept_ready", {31'd0, tok_ready}, 32'd1);
        @(negedge clk);
        tok_valid = 1'b0;
        #1;
        check("op_pop_b", {30'd0, stk_pop, stk_push}, 32'd2);
        @(negedge clk);
        check("op_pop_a", {30'd0, stk_pop, stk_push}, 32'd2);
        @(negedge clk);
        check("op_push_r", {30'd0, stk_pop, stk_push}, 32'd1);
        check("op_push_val", {24'd0, stk_wdata}, {24'd0, exp});
        check("op_busy_ready", {31'd0, tok_ready}, 32'd0);
        @(negedge clk);
        check("op_result_valid", {31'd0, result_valid}, 32'd1);
        check("op_result", {24'd0, result}, {24'd0, exp});
        check("op_ready_again", {31'd0, tok_ready}, 32'd1);
    endtask

    task automatic drain(input int exp_pops);
        int p0;
        int waited;
        p0 = pop_cnt;
        waited = 0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        while (!tok_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain_ready", {31'd0, tok_ready}, 32'd1);
        check("drain_err", {29'd0, err, err_code}, 32'd0);
        check("drain_empty", {29'd0, cnt}, 32'd0);
        check("drain_pops", pop_cnt - p0, exp_pops);
    endtask

    int        idx;
    int        cooldown;
    int        rv0;
    logic      s_is_op [0:4];
    logic [7:0] s_data [0:4];

    initial begin
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = 8'h00;
        clr       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_flags", {28'd0, result_valid, err, err_code}, 32'd0);
        check("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        check("rst_ready", {31'd0, tok_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_ready", {31'd0, tok_ready}, 32'd1);

        // 3 4 + -> 7, one entry left
        push_operand(8'd3);
        push_operand(8'd4);
        do_op(2'b00, 8'd7);
        check("add_depth", {29'd0, cnt}, 32'd1);
        // 7 0C & -> 04 ; 04 0F ^ -> 0B
        push_operand(8'h0C);
        do_op(2'b10, 8'h04);
        push_operand(8'h0F);
        do_op(2'b11, 8'h0B);
        // 5 7 - -> FE ; FF 02 + -> 01
        push_operand(8'd5);
        push_operand(8'd7);
        do_op(2'b01, 8'hFE);
        push_operand(8'hFF);
        push_operand(8'h02);
        do_op(2'b00, 8'h01);
        check("chain_depth", {29'd0, cnt}, 32'd3);
        drain(3);

        // Underflow: 9 + pops once, then errors
        push_operand(8'd9);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = 8'h00;
        @(negedge clk);
        tok_valid = 1'b0;
        #1;
        check("uf_pop_b", {31'd0, stk_pop}, 32'd1);
        @(negedge clk);
        check("uf_pop_a_none", {30'd0, stk_pop, stk_push}, 32'd0);
        @(negedge clk);
        check("uf_err", {29'd0, err, err_code}, 32'h5);
        check("uf_ready", {31'd0, tok_ready}, 32'd0);
        check("uf_empty", {31'd0, stk_empty}, 32'd1);
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("err_hold", {29'd0, err, err_code}, 32'h5);
        check("err_no_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
        check("err_keeps_result", {24'd0, result}, 32'h01);
        tok_valid = 1'b0;
        drain(0);

        // Overflow: fill the stack, then one more operand
        push_operand(8'd1);
        push_operand(8'd2);
        push_operand(8'd3);
        push_operand(8'd4);
        check("ovf_full", {31'd0, stk_full}, 32'd1);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = 8'd1;
        #1;
        check("ovf_no_push", {31'd0, stk_push}, 32'd0);
        @(negedge clk);
        tok_valid = 1'b0;
        #1;
        check("ovf_err", {29'd0, err, err_code}, 32'h6);
        check("ovf_ready", {31'd0, tok_ready}, 32'd0);
        drain(4);
        check("drain_keeps_result", {24'd0, result}, 32'h01);

        // Reset arriving while in POP_A
        push_operand(8'd3);
        push_operand(8'd4);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = 8'h00;
        @(negedge clk);
        tok_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_pop_a", {31'd0, stk_pop}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_gates_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        @(negedge clk);
        check("midrst_result", {24'd0, result}, 32'd0);
        check("midrst_flags", {28'd0, result_valid, err, err_code}, 32'd0);
        check("midrst_stack", {29'd0, cnt}, 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_ready", {31'd0, tok_ready}, 32'd1);
        idx = push_cnt + pop_cnt;
        repeat (3) @(negedge clk);
        check("midrst_quiet", push_cnt + pop_cnt, idx);

        // Streamed tokens with tok_valid held: 2 3 + 4 - -> 1
        s_is_op[0] = 1'b0; s_data[0] = 8'd2;
        s_is_op[1] = 1'b0; s_data[1] = 8'd3;
        s_is_op[2] = 1'b1; s_data[2] = 8'd0;
        s_is_op[3] = 1'b0; s_data[3] = 8'd4;
        s_is_op[4] = 1'b1; s_data[4] = 8'd1;
        idx      = 0;
        cooldown = 0;
        rv0      = rv_cnt;
        for (int cyc = 0; cyc < 60 && idx < 5; cyc++) begin
            @(negedge clk);
            tok_valid = 1'b1;
            tok_is_op = s_is_op[idx];
            tok_data  = s_data[idx];
            #1;
            if (cooldown > 0) begin
                check("stream_busy_ready", {31'd0, tok_ready}, 32'd0);
                cooldown--;
            end
            if (tok_ready) begin
                if (s_is_op[idx]) cooldown = 3;
                idx++;
            end
        end
        @(negedge clk);
        tok_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("stream_accepted", idx, 5);
        check("stream_result", {24'd0, result}, 32'd1);
        check("stream_pulses", rv_cnt - rv0, 2);
        check("stream_depth", {29'd0, cnt}, 32'd1);
        check("no_push_pop_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
